// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing the io filter output bus among NREQ requesters; owns pin_dir.
// Optional burst locking is compiled in with `define IO_ARB_LOCK_EN.
module io_arbiter #(
    parameter int NREQ       = 4,
    parameter int IO_PINS    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 8,
    localparam int PW        = $clog2(IO_PINS + 2)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREQ-1:0]                     req_valid,
    input  logic [NREQ*PW-1:0]                  req_port,
    input  logic [NREQ*DATA_WIDTH-1:0]          req_data,
    input  logic [NREQ-1:0]                     req_lock,
    output logic [NREQ-1:0]                     req_ready,
    output logic [IO_PINS+1:0]                  port_active_out,
    output logic [(IO_PINS+2)*DATA_WIDTH-1:0]   port_data_out,
    output logic [IO_PINS-1:0]                  pin_dir,
    output logic                                err,
    output logic                                locked
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(LOCK_MAX + 1);
    localparam logic [PW-1:0] CFG_PORT = PW'(IO_PINS + 1);

    logic [PTRW-1:0]       ptr;
    logic [PTRW-1:0]       ptr_nxt;
    logic [NREQ-1:0]       gnt_oh;
    logic [PTRW-1:0]       gnt_idx;
    logic                  gnt_any;
    logic                  xfer;
    logic [PW-1:0]         sel_port;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_lock;
    logic [PTRW-1:0]       ptr_after;

    function automatic logic [PTRW-1:0] wrap_inc(input logic [PTRW-1:0] i);
        return (i == PTRW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

`ifdef IO_ARB_LOCK_EN
    logic            lock_st;
    logic            lock_nxt;
    logic [PTRW-1:0] owner;
    logic [PTRW-1:0] owner_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            burst;
`else
    logic            unused_lock;
    assign unused_lock = ^req_lock;
    assign locked      = 1'b0;
`endif

    // Grant: first valid requester at or after ptr, restricted to the owner while locked
    always_comb begin
        int r;
        logic allowed;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        r       = 0;
        allowed = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            r = (int'(ptr) + i) % NREQ;
`ifdef IO_ARB_LOCK_EN
            allowed = !lock_st || (owner == PTRW'(r));
`endif
            if (!gnt_any && req_valid[r] && allowed) begin
                gnt_any    = 1'b1;
                gnt_oh[r]  = 1'b1;
                gnt_idx    = PTRW'(r);
            end
        end
    end

    assign req_ready = rst_n ? gnt_oh : '0;
    assign xfer      = gnt_any & rst_n;
    assign ptr_after = wrap_inc(gnt_idx);

    always_comb begin
        sel_port = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt_oh[r]) begin
                sel_port = req_port[r*PW +: PW];
                sel_data = req_data[r*DATA_WIDTH +: DATA_WIDTH];
                sel_lock = req_lock[r];
            end
        end
    end

`ifdef IO_ARB_LOCK_EN
    // Lock bookkeeping; ptr stays frozen for the whole burst
    always_comb begin
        lock_nxt  = lock_st;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        burst     = 1'b0;
        if (lock_st) begin
            if (xfer) begin
                burst = 1'b1;
                if (!sel_lock || cnt >= CW'(LOCK_MAX - 1)) begin
                    lock_nxt = 1'b0;
                    ptr_nxt  = ptr_after;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (!req_valid[owner] && !req_lock[owner]) begin
                lock_nxt = 1'b0;
                ptr_nxt  = wrap_inc(owner);
            end
        end else if (xfer) begin
            if (sel_lock) begin
                burst = 1'b1;
                if (LOCK_MAX > 1) begin
                    lock_nxt  = 1'b1;
                    owner_nxt = gnt_idx;
                    cnt_nxt   = CW'(1);
                end else begin
                    ptr_nxt = ptr_after;
                end
            end else begin
                ptr_nxt = ptr_after;
            end
        end
    end
`else
    assign ptr_nxt = xfer ? ptr_after : ptr;
`endif

    // Output register stage: strobe, config write or error pulse, one cycle after the transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr             <= '0;
            port_active_out <= '0;
            port_data_out   <= '0;
            pin_dir         <= '0;
            err             <= 1'b0;
`ifdef IO_ARB_LOCK_EN
            lock_st         <= 1'b0;
            owner           <= '0;
            cnt             <= '0;
            locked          <= 1'b0;
`endif
        end else begin
            ptr             <= ptr_nxt;
            port_active_out <= '0;
            port_data_out   <= '0;
            err             <= 1'b0;
            if (xfer) begin
                if (sel_port == CFG_PORT) begin
                    pin_dir <= sel_data[IO_PINS-1:0];
                end else if (sel_port > CFG_PORT) begin
                    err <= 1'b1;
                end else begin
                    for (int s = 0; s <= IO_PINS; s++) begin
                        if (sel_port == PW'(s)) begin
                            port_active_out[s]                         <= 1'b1;
                            port_data_out[s*DATA_WIDTH +: DATA_WIDTH]  <= sel_data;
                        end
                    end
                end
            end
`ifdef IO_ARB_LOCK_EN
            lock_st <= lock_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            locked  <= lock_nxt | burst;
`endif
        end
    end

endmodule

// File: tb/tb_io_arbiter.sv
// Directed table-driven bench for io_arbiter, plus reset, round-robin and lock sequences.
module tb_io_arbiter;

    localparam int NREQ       = 4;
    localparam int IO_PINS    = 16;
    localparam int DATA_WIDTH = 16;
    localparam int LOCK_MAX   = 3;
    localparam int PW         = $clog2(IO_PINS + 2);
    localparam int NP         = IO_PINS + 2;
    localparam int BUSW       = NP * DATA_WIDTH;

    logic                          clk;
    logic                          rst_n;
    logic [NREQ-1:0]               req_valid;
    logic [NREQ*PW-1:0]            req_port;
    logic [NREQ*DATA_WIDTH-1:0]    req_data;
    logic [NREQ-1:0]               req_lock;
    logic [NREQ-1:0]               req_ready;
    logic [NP-1:0]                 port_active_out;
    logic [BUSW-1:0]               port_data_out;
    logic [IO_PINS-1:0]            pin_dir;
    logic                          err;
    logic                          locked;

    int n_vec  = 0;
    int n_fail = 0;

    io_arbiter #(
        .NREQ(NREQ), .IO_PINS(IO_PINS), .DATA_WIDTH(DATA_WIDTH), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_port(req_port), .req_data(req_data), .req_lock(req_lock),
        .req_ready(req_ready), .port_active_out(port_active_out), .port_data_out(port_data_out),
        .pin_dir(pin_dir), .err(err), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]            valid;
        logic [NREQ*PW-1:0]         ports;
        logic [NREQ*DATA_WIDTH-1:0] datas;
        logic [NREQ-1:0]            exp_ready;
        int                         exp_port;
        logic [DATA_WIDTH-1:0]      exp_data;
        logic                       exp_err;
        logic [IO_PINS-1:0]         exp_dir;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [3:0] v, input int p3, p2, p1, p0,
                                input logic [15:0] d3, d2, d1, d0, input logic [3:0] rdy,
                                input int ep, input logic [15:0] ed, input logic ee,
                                input logic [15:0] dir);
        vec_t t;
        t.valid     = v;
        t.ports     = {PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
        t.datas     = {d3, d2, d1, d0};
        t.exp_ready = rdy;
        t.exp_port  = ep;
        t.exp_data  = ed;
        t.exp_err   = ee;
        t.exp_dir   = dir;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare every registered output against one expected strobe (port -1 means none)
    task automatic post(input string tag, input int p, input logic [15:0] d, input logic e,
                        input logic [IO_PINS-1:0] dir, input logic lk);
        logic [NP-1:0]   ea;
        logic [BUSW-1:0] eb;
        ea = '0;
        eb = '0;
        if (p >= 0) begin
            ea[p]                         = 1'b1;
            eb[p*DATA_WIDTH +: DATA_WIDTH] = d;
        end
        chk({tag, " active"}, BUSW'(port_active_out), BUSW'(ea));
        chk({tag, " data"},   port_data_out,          eb);
        chk({tag, " err"},    BUSW'(err),             BUSW'(e));
        chk({tag, " pin_dir"}, BUSW'(pin_dir),        BUSW'(dir));
        chk({tag, " locked"}, BUSW'(locked),          BUSW'(lk));
    endtask

    initial begin
        logic [NREQ-1:0] exp_rdy[4];
        logic            exp_lk[4];
        int              exp_g[4];

        rst_n     = 1'b0;
        req_valid = '0;
        req_port  = '0;
        req_data  = '0;
        req_lock  = '0;

        tbl[0]  = mk(4'b0000, 0, 0, 0, 0,   16'h0, 16'h0, 16'h0, 16'h0,        4'b0000, -1, 16'h0,    1'b0, 16'h0000);
        tbl[1]  = mk(4'b0100, 0, 5, 0, 0,   16'h0, 16'h0001, 16'h0, 16'h0,     4'b0100,  5, 16'h0001, 1'b0, 16'h0000);
        tbl[2]  = mk(4'b0000, 0, 0, 0, 0,   16'h0, 16'h0, 16'h0, 16'h0,        4'b0000, -1, 16'h0,    1'b0, 16'h0000);
        tbl[3]  = mk(4'b1111, 4, 3, 2, 1,   16'hA3, 16'hA2, 16'hA1, 16'hA0,    4'b1000,  4, 16'hA3,   1'b0, 16'h0000);
        tbl[4]  = mk(4'b0111, 4, 3, 2, 1,   16'hA3, 16'hA2, 16'hA1, 16'hA0,    4'b0001,  1, 16'hA0,   1'b0, 16'h0000);
        tbl[5]  = mk(4'b0110, 4, 3, 2, 1,   16'hA3, 16'hA2, 16'hA1, 16'hA0,    4'b0010,  2, 16'hA1,   1'b0, 16'h0000);
        tbl[6]  = mk(4'b0100, 4, 3, 2, 1,   16'hA3, 16'hA2, 16'hA1, 16'hA0,    4'b0100,  3, 16'hA2,   1'b0, 16'h0000);
        tbl[7]  = mk(4'b0001, 0, 0, 0, 17,  16'h0, 16'h0, 16'h0, 16'h00FF,     4'b0001, -1, 16'h0,    1'b0, 16'h00FF);
        tbl[8]  = mk(4'b0010, 0, 0, 20, 0,  16'h0, 16'h0, 16'h1234, 16'h0,     4'b0010, -1, 16'h0,    1'b1, 16'h00FF);
        tbl[9]  = mk(4'b0000, 0, 0, 0, 0,   16'h0, 16'h0, 16'h0, 16'h0,        4'b0000, -1, 16'h0,    1'b0, 16'h00FF);
        tbl[10] = mk(4'b1010, 16, 0, 16, 0, 16'hCAFE, 16'h0, 16'hBEEF, 16'h0,  4'b1000, 16, 16'hCAFE, 1'b0, 16'h00FF);
        tbl[11] = mk(4'b0010, 0, 0, 16, 0,  16'h0, 16'h0, 16'hBEEF, 16'h0,     4'b0010, 16, 16'hBEEF, 1'b0, 16'h00FF);
        tbl[12] = mk(4'b1000, 0, 0, 0, 0,   16'hFFFF, 16'h0, 16'h0, 16'h0,     4'b1000,  0, 16'hFFFF, 1'b0, 16'h00FF);
        tbl[13] = mk(4'b0001, 0, 0, 0, 15,  16'h0, 16'h0, 16'h0, 16'h8001,     4'b0001, 15, 16'h8001, 1'b0, 16'h00FF);
        tbl[14] = mk(4'b0100, 0, 17, 0, 0,  16'h0, 16'h5A5A, 16'h0, 16'h0,     4'b0100, -1, 16'h0,    1'b0, 16'h5A5A);
        tbl[15] = mk(4'b0000, 0, 0, 0, 0,   16'h0, 16'h0, 16'h0, 16'h0,        4'b0000, -1, 16'h0,    1'b0, 16'h5A5A);

        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", BUSW'(req_ready), '0);
        post("reset", -1, 16'h0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            req_valid = tbl[i].valid;
            req_port  = tbl[i].ports;
            req_data  = tbl[i].datas;
            #3;
            chk($sformatf("v%0d ready", i), BUSW'(req_ready), BUSW'(tbl[i].exp_ready));
            @(posedge clk);
            #1;
            post($sformatf("v%0d", i), tbl[i].exp_port, tbl[i].exp_data, tbl[i].exp_err,
                 tbl[i].exp_dir, 1'b0);
        end

        // Reset mid-stream drops the in-flight strobe and clears pin_dir
        req_valid = 4'b0001;
        req_port  = {PW'(0), PW'(0), PW'(0), PW'(7)};
        req_data  = {16'h0, 16'h0, 16'h0, 16'h7777};
        @(posedge clk);
        #1;
        post("pre-reset", 7, 16'h7777, 1'b0, 16'h5A5A, 1'b0);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_port  = {PW'(3), PW'(2), PW'(1), PW'(0)};
        req_data  = {16'h13, 16'h12, 16'h11, 16'h10};
        #3;
        chk("ready in reset", BUSW'(req_ready), '0);
        @(posedge clk);
        #1;
        post("mid-reset", -1, 16'h0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;

        // All requesters valid continuously: 0,1,2,3,0,... with back-to-back strobes
        for (int k = 0; k < 8; k++) begin
            #3;
            chk($sformatf("rr%0d ready", k), BUSW'(req_ready), BUSW'(4'b0001 << (k % 4)));
            @(posedge clk);
            #1;
            post($sformatf("rr%0d", k), k % 4, 16'h10 + 16'(k % 4), 1'b0, '0, 1'b0);
        end

        // Move ptr to 1, then requester 1 holds lock with everyone valid
        req_valid = 4'b0001;
        #3;
        chk("pre-lock ready", BUSW'(req_ready), BUSW'(4'b0001));
        @(posedge clk);
        #1;
        post("pre-lock", 0, 16'h10, 1'b0, '0, 1'b0);

`ifdef IO_ARB_LOCK_EN
        exp_g  = '{1, 1, 1, 2};
        exp_lk = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
        exp_g  = '{1, 2, 3, 0};
        exp_lk = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 4; k++) exp_rdy[k] = 4'b0001 << exp_g[k];

        req_valid = 4'b1111;
        req_lock  = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk($sformatf("lk%0d ready", k), BUSW'(req_ready), BUSW'(exp_rdy[k]));
            @(posedge clk);
            #1;
            post($sformatf("lk%0d", k), exp_g[k], 16'h10 + 16'(exp_g[k]), 1'b0, '0, exp_lk[k]);
        end

        req_valid = '0;
        req_lock  = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
